lcd_nibble_driver: RTL

LCD_NIBBLE_DRIVER -- requirements
Module: lcd_nibble_driver

---
 rtl/lcd_pkg.sv | 49 ++++
 rtl/lcd_nibble_driver_if.sv | 21 ++
 rtl/lcd_delay_counter.sv | 48 ++++
 rtl/lcd_nibble_driver.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780-style 4-bit LCD write path: driver FSM
// state encoding, default timing constants (cycles at 50 MHz), counter width
// and the instruction codes that need the long execution wait.
// Imported by the driver and by any controller that issues commands to it.
// -----------------------------------------------------------------------------
package lcd_pkg;

  typedef enum logic [3:0] {
    PWRUP,
    IDLE,
    SETUP_H,
    PULSE_H,
    HOLD_H,
    GAP,
    SETUP_L,
    PULSE_L,
    HOLD_L,
    EXEC,
    RDY,
    TURN
  } state_e;

  // Delay counter width; large enough for the 15 ms power-on wait.
  localparam int CNT_W = 20;

  // Default timing, in clock cycles at 50 MHz.
  localparam int DEF_SETUP     = 2;       // 40 ns RS/DB setup before E
  localparam int DEF_EPW       = 13;      // >= 250 ns E high
  localparam int DEF_HOLD      = 1;       // hold after E falls
  localparam int DEF_GAP       = 50;      // 1 us between nibbles
  localparam int DEF_EXEC      = 2100;    // 42 us normal command
  localparam int DEF_EXEC_LONG = 82000;   // 1.64 ms clear/home
  localparam int DEF_PWRUP     = 750000;  // 15 ms power-on
  localparam int DEF_INIT_W1   = 205000;  // 4.1 ms after first wake nibble
  localparam int DEF_INIT_W2   = 5000;    // 100 us after second wake nibble
  localparam int TURN_CYCLES   = 2;       // idle gap after rdy

  // Instruction codes.
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Clear and both encodings of return-home (0x02/0x03) need the long wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && (b == CMD_CLEAR || b == CMD_HOME || b == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_nibble_driver_if.sv
// -----------------------------------------------------------------------------
// lcd_nibble_driver_if
// Request/acknowledge handshake between an LCD controller and the nibble
// driver.
//   en      : controller requests a byte write
//   rs_in   : 0 = instruction, 1 = data
//   data_in : byte to write
//   rdy     : one-cycle completion pulse from the driver
//   busy    : driver has a transaction (or power-up) in progress
// Modports: master = controller side, slave = driver side.
// -----------------------------------------------------------------------------
interface lcd_nibble_driver_if;
  logic       en;
  logic       rs_in;
  logic [7:0] data_in;
  logic       rdy;
  logic       busy;

  modport master (output en, rs_in, data_in, input rdy, busy);
  modport slave  (input en, rs_in, data_in, output rdy, busy);
endinterface

// File: rtl/lcd_delay_counter.sv
// -----------------------------------------------------------------------------
// lcd_delay_counter
// Loadable down-counter used for every timed FSM state. Loading N-1 makes
// done rise after N cycles in the state. Saturates at zero (no wrap).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (count clears to 0)
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load
//   cnt_en     : decrement enable
//   done       : count is zero
// -----------------------------------------------------------------------------
module lcd_delay_counter
  import lcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             cnt_en,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: give every combinational output a default first so no path leaves
  // it unassigned, otherwise synthesis infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_en && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/lcd_nibble_driver.sv
// -----------------------------------------------------------------------------
// lcd_nibble_driver
// Writes one byte to an HD44780-style LCD over a 4-bit bus: high nibble,
// gap, low nibble, then the command execution wait, then a one-cycle rdy.
// Waits the power-on delay after reset before accepting requests.
// Optional: define LCD_DRV_INIT_SEQ_EN to emit the 4-bit wake sequence
// (nibbles 3,3,3,2) after power-on and before the first IDLE.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   host       : lcd_nibble_driver_if.slave (en/rs_in/data_in in, rdy/busy out)
//   lcd_rs     : register select to the panel
//   lcd_rw     : read/write, always write (0)
//   lcd_e      : enable strobe
//   lcd_db     : DB7..DB4
// All panel and handshake outputs are registered.
// -----------------------------------------------------------------------------
module lcd_nibble_driver
  import lcd_pkg::*;
#(
  parameter int P_SETUP     = DEF_SETUP,
  parameter int P_EPW       = DEF_EPW,
  parameter int P_HOLD      = DEF_HOLD,
  parameter int P_GAP       = DEF_GAP,
  parameter int P_EXEC      = DEF_EXEC,
  parameter int P_EXEC_LONG = DEF_EXEC_LONG,
  parameter int P_PWRUP     = DEF_PWRUP
`ifdef LCD_DRV_INIT_SEQ_EN
  , parameter int P_INIT_W1 = DEF_INIT_W1
  , parameter int P_INIT_W2 = DEF_INIT_W2
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  lcd_nibble_driver_if.slave  host,
  output logic                lcd_rs,
  output logic                lcd_rw,
  output logic                lcd_e,
  output logic [3:0]          lcd_db
);

  // Counter load values: a state lasting N cycles loads N-1.
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(P_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_EPW   = CNT_W'(P_EPW - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(P_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(P_GAP - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(P_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(P_EXEC_LONG - 1);
  localparam logic [CNT_W-1:0] LD_TURN  = CNT_W'(TURN_CYCLES - 1);
  // The counter clears to 0 on reset, so PWRUP spends its first cycle
  // arming the counter; hence two fewer than the full wait.
  localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(P_PWRUP - 2);
`ifdef LCD_DRV_INIT_SEQ_EN
  localparam logic [CNT_W-1:0] LD_INIT1 = CNT_W'(P_INIT_W1 - 1);
  localparam logic [CNT_W-1:0] LD_INIT2 = CNT_W'(P_INIT_W2 - 1);
`endif

  state_e     state_q, state_d;
  logic       armed_q, armed_d;
  logic       rs_q, rs_d;
  logic [7:0] data_q, data_d;
  logic       rdy_q, rdy_d;
  logic       busy_q, busy_d;
  logic       lcd_e_q, lcd_e_d;
  logic       lcd_rs_q, lcd_rs_d;
  logic [3:0] lcd_db_q, lcd_db_d;
`ifdef LCD_DRV_INIT_SEQ_EN
  logic       init_q, init_d;
  logic [1:0] step_q, step_d;
`endif

  logic             ld;
  logic [CNT_W-1:0] ld_val;
  logic             cnt_done;
  logic             in_h, in_l;

  lcd_delay_counter u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .load_val (ld_val),
    .cnt_en   (state_q != IDLE),
    .done     (cnt_done)
  );

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    rs_d    = rs_q;
    data_d  = data_q;
    ld      = 1'b0;
    ld_val  = '0;
`ifdef LCD_DRV_INIT_SEQ_EN
    init_d  = init_q;
    step_d  = step_q;
`endif

    unique case (state_q)
      PWRUP: begin
        if (!armed_q) begin
          armed_d = 1'b1;
          ld      = 1'b1;
          ld_val  = LD_PWRUP;
        end else if (cnt_done) begin
`ifdef LCD_DRV_INIT_SEQ_EN
          state_d = SETUP_H;
          init_d  = 1'b1;
          step_d  = 2'd0;
          rs_d    = 1'b0;
          data_d  = 8'h30;
`else
          state_d = IDLE;
`endif
        end
      end
      IDLE: begin
        if (host.en) begin
          rs_d    = host.rs_in;
          data_d  = host.data_in;
          state_d = SETUP_H;
        end
      end
      SETUP_H: if (cnt_done) state_d = PULSE_H;
      PULSE_H: if (cnt_done) state_d = HOLD_H;
      HOLD_H: begin
        if (cnt_done) begin
          state_d = GAP;
`ifdef LCD_DRV_INIT_SEQ_EN
          // Wake nibbles are single 4-bit writes: no low nibble.
          if (init_q) state_d = EXEC;
`endif
        end
      end
      GAP:     if (cnt_done) state_d = SETUP_L;
      SETUP_L: if (cnt_done) state_d = PULSE_L;
      PULSE_L: if (cnt_done) state_d = HOLD_L;
      HOLD_L:  if (cnt_done) state_d = EXEC;
      EXEC: begin
        if (cnt_done) begin
          state_d = RDY;
`ifdef LCD_DRV_INIT_SEQ_EN
          if (init_q) begin
            if (step_q == 2'd3) begin
              init_d  = 1'b0;
              state_d = IDLE;
            end else begin
              step_d  = step_q + 2'd1;
              data_d  = (step_q == 2'd2) ? 8'h20 : 8'h30;
              state_d = SETUP_H;
            end
          end
`endif
        end
      end
      RDY:  state_d = TURN;
      TURN: if (cnt_done) state_d = IDLE;
      default: state_d = PWRUP;
    endcase

    // Every state entry reloads the counter with that state's duration.
    if (state_d != state_q) begin
      ld = 1'b1;
      unique case (state_d)
        SETUP_H, SETUP_L: ld_val = LD_SETUP;
        PULSE_H, PULSE_L: ld_val = LD_EPW;
        HOLD_H, HOLD_L:   ld_val = LD_HOLD;
        GAP:              ld_val = LD_GAP;
        TURN:             ld_val = LD_TURN;
        EXEC: begin
`ifdef LCD_DRV_INIT_SEQ_EN
          if (init_q) begin
            unique case (step_q)
              2'd0:    ld_val = LD_INIT1;
              2'd1:    ld_val = LD_INIT2;
              default: ld_val = LD_EXEC;
            endcase
          end else
`endif
          ld_val = is_long_cmd(rs_q, data_q) ? LD_LONG : LD_EXEC;
        end
        default: ld_val = '0;
      endcase
    end

    // Outputs are derived from the next state so they change together with it.
    in_h     = state_d inside {SETUP_H, PULSE_H, HOLD_H};
    in_l     = state_d inside {SETUP_L, PULSE_L, HOLD_L};
    lcd_e_d  = state_d inside {PULSE_H, PULSE_L};
    lcd_rs_d = (in_h || in_l) && rs_d;
    lcd_db_d = in_h ? data_d[7:4] : (in_l ? data_d[3:0] : 4'h0);
    busy_d   = (state_d != IDLE);
    rdy_d    = (state_d == RDY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PWRUP;
      armed_q  <= 1'b0;
      rs_q     <= 1'b0;
      data_q   <= '0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b1;
      lcd_e_q  <= 1'b0;
      lcd_rs_q <= 1'b0;
      lcd_db_q <= '0;
`ifdef LCD_DRV_INIT_SEQ_EN
      init_q   <= 1'b0;
      step_q   <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      rs_q     <= rs_d;
      data_q   <= data_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
      lcd_e_q  <= lcd_e_d;
      lcd_rs_q <= lcd_rs_d;
      lcd_db_q <= lcd_db_d;
`ifdef LCD_DRV_INIT_SEQ_EN
      init_q   <= init_d;
      step_q   <= step_d;
`endif
    end
  end

  assign host.rdy  = rdy_q;
  assign host.busy = busy_q;
  assign lcd_e     = lcd_e_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_db    = lcd_db_q;
  assign lcd_rw    = 1'b0;

endmodule
